md4_round_sequencer: RTL and testbench

- Iterative MD4 compression controller: one shared step unit, one step per clock, 48 steps (3 rounds x 16) over one captured 512-bit block.
- Sequences the round function (F/G/H), message-word index, shift amount and round constant.
- Applies the final chaining feed-forward and hands a 128-bit state to the padding/multi-block front end.
- Sits between the block buffer and the digest output register.

---
 rtl/md4_round_sequencer.sv | 154 +++++++++++++++
 tb/tb_md4_round_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/md4_round_sequencer.sv
// Iterative MD4 compression: 48 steps, one per clock, on one captured block.
// Latency 49 cycles from start to done; start is ignored while busy.
module md4_round_sequencer #(
  parameter bit FEED_FORWARD = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  output logic         busy,
  output logic         done,
  output logic [5:0]   step,
  output logic [31:0]  out_a,
  output logic [31:0]  out_b,
  output logic [31:0]  out_c,
  output logic [31:0]  out_d
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_nxt;
  logic [511:0]  blk_q;
  logic [31:0]   cap_a, cap_b, cap_c, cap_d;
  logic [31:0]   wa, wb, wc, wd;
  logic [5:0]    step_q;
  logic          done_q;
  logic          last_step;

  logic [1:0]    rnd;
  logic [3:0]    idx;
  logic [31:0]   fn, kc, xw, sum, rot;
  logic [3:0]    widx;
  logic [4:0]    sh;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  assign last_step = (step_q == 6'd47);
  assign rnd       = step_q[5:4];
  assign idx       = step_q[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Round function, constant, message word and shift for the current step.
  always_comb begin
    fn   = 32'd0;
    kc   = 32'd0;
    widx = 4'd0;
    sh   = 5'd0;
    case (rnd)
      2'd0: begin
        fn   = (wb & wc) | (~wb & wd);
        widx = idx;
        case (idx[1:0])
          2'd0: sh = 5'd3;
          2'd1: sh = 5'd7;
          2'd2: sh = 5'd11;
          default: sh = 5'd19;
        endcase
      end
      2'd1: begin
        fn   = (wb & wc) | (wb & wd) | (wc & wd);
        kc   = 32'h5A827999;
        widx = {idx[1:0], idx[3:2]};
        case (idx[1:0])
          2'd0: sh = 5'd3;
          2'd1: sh = 5'd5;
          2'd2: sh = 5'd9;
          default: sh = 5'd13;
        endcase
      end
      default: begin
        fn   = wb ^ wc ^ wd;
        kc   = 32'h6ED9EBA1;
        widx = {idx[0], idx[1], idx[2], idx[3]};
        case (idx[1:0])
          2'd0: sh = 5'd3;
          2'd1: sh = 5'd9;
          2'd2: sh = 5'd11;
          default: sh = 5'd15;
        endcase
      end
    endcase
  end

  assign xw  = blk_q[{widx, 5'd0} +: 32];
  assign sum = wa + fn + xw + kc;
  assign rot = rotl(sum, sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q  <= '0;
      cap_a  <= '0; cap_b <= '0; cap_c <= '0; cap_d <= '0;
      wa     <= '0; wb    <= '0; wc    <= '0; wd    <= '0;
      step_q <= '0;
      done_q <= 1'b0;
      out_a  <= '0; out_b <= '0; out_c <= '0; out_d <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          blk_q  <= block;
          cap_a  <= a_in; cap_b <= b_in; cap_c <= c_in; cap_d <= d_in;
          wa     <= a_in; wb    <= b_in; wc    <= c_in; wd    <= d_in;
          step_q <= 6'd0;
        end
        // Rotating register form of the standard a/d/c/b argument rotation.
        RUN: begin
          wa <= wd;
          wb <= rot;
          wc <= wb;
          wd <= wc;
          if (!last_step) step_q <= step_q + 6'd1;
        end
        FIN: begin
          done_q <= 1'b1;
          out_a  <= FEED_FORWARD ? wa + cap_a : wa;
          out_b  <= FEED_FORWARD ? wb + cap_b : wb;
          out_c  <= FEED_FORWARD ? wc + cap_c : wc;
          out_d  <= FEED_FORWARD ? wd + cap_d : wd;
        end
        default: ;
      endcase
    end
  end

  assign done = done_q;
  assign step = step_q;

endmodule

// File: tb/tb_md4_round_sequencer.sv
// Directed bench for md4_round_sequencer: known MD4 vectors, busy/start handling,
// back-to-back blocks, async reset abort and a raw-state (no feed-forward) build.
module tb_md4_round_sequencer;

  typedef struct packed {
    logic [31:0] a, b, c, d;
  } dig_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start2 = 1'b0;
  logic [511:0] block = '0;
  logic [31:0]  a_in = '0, b_in = '0, c_in = '0, d_in = '0;

  logic         busy, done, busy2, done2;
  logic [5:0]   step, step2;
  logic [31:0]  out_a, out_b, out_c, out_d;
  logic [31:0]  o2_a, o2_b, o2_c, o2_d;

  int n_cmp = 0;
  int n_bad = 0;

  dig_t q1[$];
  dig_t q2[$];

  localparam logic [31:0] IV_A = 32'h67452301, IV_B = 32'hEFCDAB89;
  localparam logic [31:0] IV_C = 32'h98BADCFE, IV_D = 32'h10325476;
  localparam dig_t EMPTY_DIG = '{32'hE0CFD631, 32'h31E96AD1, 32'hD7593CB7, 32'hC089C0E0};
  localparam dig_t ABC_DIG   = '{32'h7A0148A4, 32'h52D821AF, 32'hE80AC15F, 32'h9D72A67A};

  md4_round_sequencer #(.FEED_FORWARD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block(block),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .busy(busy), .done(done), .step(step),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d)
  );

  md4_round_sequencer #(.FEED_FORWARD(1'b0)) dut_raw (
    .clk(clk), .rst_n(rst_n), .start(start2), .block(block),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .busy(busy2), .done(done2), .step(step2),
    .out_a(o2_a), .out_b(o2_b), .out_c(o2_c), .out_d(o2_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] empty_blk();
    logic [511:0] b;
    b = '0;
    b[31:0] = 32'h00000080;
    return b;
  endfunction

  function automatic logic [511:0] abc_blk();
    logic [511:0] b;
    b = '0;
    b[31:0]    = 32'h80636261;
    b[479:448] = 32'h00000018;
    return b;
  endfunction

  task automatic drive_iv(input logic [511:0] b);
    block = b;
    a_in = IV_A; b_in = IV_B; c_in = IV_C; d_in = IV_D;
  endtask

  // Pulse start for one edge on the main DUT, then scramble the inputs.
  task automatic issue(input logic [511:0] b, input dig_t exp);
    drive_iv(b);
    start = 1'b1;
    q1.push_back(exp);
    tick();
    start = 1'b0;
    block = {16{$urandom}};
    a_in = $urandom; b_in = $urandom; c_in = $urandom; d_in = $urandom;
  endtask

  // Called one tick after the accept edge; waits for done and scores the result.
  task automatic wait_done(input string tag, input bit inject);
    int   cnt;
    int   bsy_bad;
    dig_t e;
    cnt = 0;
    bsy_bad = 0;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    while (cnt < 60) begin
      tick();
      cnt++;
      if (done) break;
      if (!busy) bsy_bad++;
      if (cnt == 20) check({tag, "_step20"}, 32'(step), 32'd20);
      if (cnt == 48) check({tag, "_step_sat"}, 32'(step), 32'd47);
      if (inject && (cnt == 10 || cnt == 48)) begin
        block = {16{32'hDEADBEEF}};
        a_in = 32'h1; b_in = 32'h2; c_in = 32'h3; d_in = 32'h4;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cnt), 32'd49);
    check({tag, "_busy_run"}, 32'(bsy_bad), 32'd0);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (q1.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(q1.size()), 32'd1);
    end else begin
      e = q1.pop_front();
      check({tag, "_a"}, out_a, e.a);
      check({tag, "_b"}, out_b, e.b);
      check({tag, "_c"}, out_c, e.c);
      check({tag, "_d"}, out_d, e.d);
    end
  endtask

  initial begin
    int   cnt;
    int   extra;
    dig_t e;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_out", out_a | out_b | out_c | out_d, 32'd0);
    rst_n = 1'b1;
    tick();

    // Empty message with starts injected at cycles 10 and 48.
    issue(empty_blk(), EMPTY_DIG);
    wait_done("empty", 1'b1);
    extra = 0;
    repeat (60) begin
      tick();
      if (done) extra++;
    end
    check("ignored_starts_done", 32'(extra), 32'd0);
    check("hold_a", out_a, EMPTY_DIG.a);

    // Empty then "abc" back to back: second start in the done cycle.
    issue(empty_blk(), EMPTY_DIG);
    wait_done("b2b1", 1'b0);
    issue(abc_blk(), ABC_DIG);
    wait_done("b2b2", 1'b0);
    tick();

    // Asynchronous reset at step 20 aborts the block.
    issue(empty_blk(), EMPTY_DIG);
    repeat (20) tick();
    check("pre_rst_step", 32'(step), 32'd20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_step", 32'(step), 32'd0);
    check("arst_out", out_a | out_b | out_c | out_d, 32'd0);
    void'(q1.pop_front());
    #3 rst_n = 1'b1;
    extra = 0;
    repeat (60) begin
      tick();
      if (done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    issue(empty_blk(), EMPTY_DIG);
    wait_done("after_rst", 1'b0);

    // Raw-state build: digest minus IV per word.
    e.a = EMPTY_DIG.a - IV_A;
    e.b = EMPTY_DIG.b - IV_B;
    e.c = EMPTY_DIG.c - IV_C;
    e.d = EMPTY_DIG.d - IV_D;
    q2.push_back(e);
    drive_iv(empty_blk());
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cnt = 0;
    while (cnt < 60) begin
      tick();
      cnt++;
      if (done2) break;
    end
    check("raw_latency", 32'(cnt), 32'd49);
    e = q2.pop_front();
    check("raw_a", o2_a, e.a);
    check("raw_a_const", o2_a, 32'h798AB330);
    check("raw_b", o2_b, e.b);
    check("raw_c", o2_c, e.c);
    check("raw_d", o2_d, e.d);
    check("sb_drained", 32'(q1.size() + q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
